// File: rtl/mining_ctrl_param.sv
// Nonce-search controller: for each nonce it patches the header in BRAM, streams the
// chunks through an external SHA-256 core and tests the digest against a difficulty.
module mining_ctrl_param #(
  parameter int CHUNK_W    = 512,
  parameter int ADDR_W     = 16,
  parameter int NONCE_W    = 32,
  parameter int POS_W      = 9,
  parameter int MAX_CHUNKS = 16,
  parameter int HASH_W     = 256,
  localparam int CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [CNT_W-1:0]   num_chunks_i,
  input  logic [ADDR_W-1:0]  nonce_addr_i,
  input  logic [POS_W-1:0]   nonce_pos_i,
  input  logic [NONCE_W-1:0] nonce_start_i,
  input  logic [NONCE_W-1:0] nonce_end_i,
  input  logic [8:0]         difficulty_i,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_rd_en_o,
  output logic               mem_wr_en_o,
  output logic [POS_W-1:0]   mem_wpos_o,
  output logic [NONCE_W-1:0] mem_wdata_o,
  input  logic [CHUNK_W-1:0] mem_rdata_i,
  output logic               sha_start_o,
  output logic               sha_init_o,
  output logic [CHUNK_W-1:0] sha_chunk_o,
  input  logic               sha_done_i,
  input  logic [HASH_W-1:0]  sha_hash_i,
  output logic               busy_o,
  output logic               found_o,
  output logic               exhausted_o,
  output logic [NONCE_W-1:0] nonce_out_o,
  output logic [NONCE_W-1:0] attempts_o,
  output logic [3:0]         state_o
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_NONCE  = 4'd1;
  localparam logic [3:0] S_RD_REQ    = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_SHA_GO    = 4'd4;
  localparam logic [3:0] S_SHA_WAIT  = 4'd5;
  localparam logic [3:0] S_CHECK     = 4'd6;
  localparam logic [3:0] S_FOUND     = 4'd7;
  localparam logic [3:0] S_EXHAUSTED = 4'd8;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CHUNKS);
  localparam logic [8:0]       MAX_DIFF = 9'd256;

  logic [3:0]         state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] end_q, end_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   chunks_q, chunks_d;
  logic [ADDR_W-1:0]  naddr_q, naddr_d;
  logic [POS_W-1:0]   npos_q, npos_d;
  logic [8:0]         diff_q, diff_d;
  logic               found_q, found_d;
  logic               exh_q, exh_d;
  logic [NONCE_W-1:0] nout_q, nout_d;
  logic [NONCE_W-1:0] att_q, att_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;

  logic [CNT_W-1:0]   chunks_eff;
  logic [8:0]         diff_eff;
  logic [HASH_W-1:0]  hash_mask;
  logic               hit;
  logic               load_cfg;

  always_comb begin
    if (num_chunks_i == '0)          chunks_eff = CNT_W'(1);
    else if (num_chunks_i > MAX_CNT) chunks_eff = MAX_CNT;
    else                             chunks_eff = num_chunks_i;
    diff_eff  = (difficulty_i > MAX_DIFF) ? MAX_DIFF : difficulty_i;
    // Mask covers the top diff_q bits; a shift of HASH_W or more leaves the whole digest masked.
    hash_mask = ~({HASH_W{1'b1}} >> diff_q);
    hit       = ((sha_hash_i & hash_mask) == '0);
  end

  always_comb begin
    state_d  = state_q;
    nonce_d  = nonce_q;
    end_d    = end_q;
    idx_d    = idx_q;
    chunks_d = chunks_q;
    naddr_d  = naddr_q;
    npos_d   = npos_q;
    diff_d   = diff_q;
    found_d  = found_q;
    exh_d    = exh_q;
    nout_d   = nout_q;
    att_d    = att_q;
    chunk_d  = chunk_q;
    load_cfg = 1'b0;

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (start_i) load_cfg = 1'b1;
        S_WR_NONCE: begin
          idx_d   = '0;
          state_d = S_RD_REQ;
        end
        S_RD_REQ:    state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          chunk_d = mem_rdata_i;
          state_d = S_SHA_GO;
        end
        S_SHA_GO:    state_d = S_SHA_WAIT;
        S_SHA_WAIT: begin
          if (sha_done_i) begin
            if (idx_q == chunks_q - 1'b1) begin
              state_d = S_CHECK;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_RD_REQ;
            end
          end
        end
        S_CHECK: begin
          if (att_q != '1) att_d = att_q + 1'b1;
          if (hit) begin
            nout_d  = nonce_q;
            found_d = 1'b1;
            state_d = S_FOUND;
          end else if (nonce_q == end_q) begin
            exh_d   = 1'b1;
            state_d = S_EXHAUSTED;
          end else begin
            nonce_d = nonce_q + 1'b1;
            state_d = S_WR_NONCE;
          end
        end
        S_FOUND, S_EXHAUSTED: if (start_i) load_cfg = 1'b1;
        default:     state_d = S_IDLE;
      endcase
    end

    if (load_cfg) begin
      chunks_d = chunks_eff;
      naddr_d  = nonce_addr_i;
      npos_d   = nonce_pos_i;
      nonce_d  = nonce_start_i;
      end_d    = nonce_end_i;
      diff_d   = diff_eff;
      found_d  = 1'b0;
      exh_d    = 1'b0;
      att_d    = '0;
      state_d  = S_WR_NONCE;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      nonce_q  <= '0;
      end_q    <= '0;
      idx_q    <= '0;
      chunks_q <= '0;
      naddr_q  <= '0;
      npos_q   <= '0;
      diff_q   <= '0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      nout_q   <= '0;
      att_q    <= '0;
      chunk_q  <= '0;
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      end_q    <= end_d;
      idx_q    <= idx_d;
      chunks_q <= chunks_d;
      naddr_q  <= naddr_d;
      npos_q   <= npos_d;
      diff_q   <= diff_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      nout_q   <= nout_d;
      att_q    <= att_d;
      chunk_q  <= chunk_d;
    end
  end

  // Strobes are gated by abort so they drop in the very cycle abort is raised.
  always_comb begin
    mem_wr_en_o = (state_q == S_WR_NONCE) && !abort_i;
    mem_rd_en_o = (state_q == S_RD_REQ) && !abort_i;
    sha_start_o = (state_q == S_SHA_GO) && !abort_i;
    sha_init_o  = sha_start_o && (idx_q == '0);
    if (state_q == S_WR_NONCE)    mem_addr_o = naddr_q;
    else if (state_q == S_RD_REQ) mem_addr_o = ADDR_W'(idx_q);
    else                          mem_addr_o = '0;
  end

  assign mem_wpos_o  = npos_q;
  assign mem_wdata_o = nonce_q;
  assign sha_chunk_o = chunk_q;
  assign busy_o      = (state_q != S_IDLE);
  assign found_o     = found_q;
  assign exhausted_o = exh_q;
  assign nonce_out_o = nout_q;
  assign attempts_o  = att_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mining_ctrl_param.sv
// Bench for mining_ctrl_param: BRAM and SHA-core models plus a nonce-sweep reference
// model that predicts writes, attempts, outcome and cycle counts for each search.
module tb_mining_ctrl_param;

  localparam int CHUNK_W    = 512;
  localparam int ADDR_W     = 16;
  localparam int NONCE_W    = 32;
  localparam int POS_W      = 9;
  localparam int MAX_CHUNKS = 16;
  localparam int HASH_W     = 256;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);

  logic               clock = 1'b0;
  logic               resetN = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [CNT_W-1:0]   numChunks = '0;
  logic [ADDR_W-1:0]  nonceAddr = '0;
  logic [POS_W-1:0]   noncePos = '0;
  logic [NONCE_W-1:0] nonceStart = '0;
  logic [NONCE_W-1:0] nonceEnd = '0;
  logic [8:0]         difficulty = '0;
  logic [ADDR_W-1:0]  memAddr;
  logic               memRdEn, memWrEn, shaStart, shaInit;
  logic [POS_W-1:0]   memWpos;
  logic [NONCE_W-1:0] memWdata;
  logic [CHUNK_W-1:0] memRdata = '0;
  logic [CHUNK_W-1:0] shaChunk;
  logic               shaDone = 1'b0;
  logic [HASH_W-1:0]  shaHash = '1;
  logic               busy, found, exhausted;
  logic [NONCE_W-1:0] nonceOut, attempts;
  logic [3:0]         stateOut;

  int vectors = 0;
  int miscompares = 0;

  mining_ctrl_param dut (
    .clock_i(clock), .reset_ni(resetN), .start_i(start), .abort_i(abort),
    .num_chunks_i(numChunks), .nonce_addr_i(nonceAddr), .nonce_pos_i(noncePos),
    .nonce_start_i(nonceStart), .nonce_end_i(nonceEnd), .difficulty_i(difficulty),
    .mem_addr_o(memAddr), .mem_rd_en_o(memRdEn), .mem_wr_en_o(memWrEn),
    .mem_wpos_o(memWpos), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata),
    .sha_start_o(shaStart), .sha_init_o(shaInit), .sha_chunk_o(shaChunk),
    .sha_done_i(shaDone), .sha_hash_i(shaHash), .busy_o(busy), .found_o(found),
    .exhausted_o(exhausted), .nonce_out_o(nonceOut), .attempts_o(attempts),
    .state_o(stateOut)
  );

  always #5 clock = ~clock;

  int                 shaLat = 3;
  int                 hashMode = 0;
  logic [NONCE_W-1:0] hashTarget = '0;
  logic [31:0]        hashSeed = 32'h1234_5678;
  logic [NONCE_W-1:0] curNonce = '0;

  function automatic logic [CHUNK_W-1:0] chunkPattern(input logic [ADDR_W-1:0] a);
    logic [CHUNK_W-1:0] c;
    for (int i = 0; i < CHUNK_W / 32; i++) c[i*32 +: 32] = {a, a ^ 16'hA5C3 ^ 16'(i)};
    return c;
  endfunction

  // Digest depends only on the nonce under test: mode 0 never hits, 1 hits a single
  // target with 12 leading zeros, 2 is pseudo-random, 3 is all zeros.
  function automatic logic [HASH_W-1:0] hashOf(input logic [NONCE_W-1:0] n);
    logic [HASH_W-1:0] h;
    logic [31:0] m;
    h = '1;
    case (hashMode)
      1: if (n == hashTarget) h[HASH_W-1 -: 20] = 20'h000FF;
      2: begin
        m = (n * 32'h9E37_79B1) ^ hashSeed;
        h[HASH_W-1 -: 32] = m >> (n % 5);
      end
      3: h = '0;
      default: ;
    endcase
    return h;
  endfunction

  function automatic int leadingZeros(input logic [HASH_W-1:0] h);
    int c;
    c = 0;
    for (int i = HASH_W - 1; i >= 0; i--) begin
      if (h[i]) break;
      c++;
    end
    return c;
  endfunction

  // BRAM and SHA-core models; done arrives shaLat cycles after the start cycle.
  logic shaBusy = 1'b0;
  int   shaCnt = 0;
  always @(posedge clock) begin
    shaDone <= 1'b0;
    if (shaBusy) begin
      if (shaCnt <= 1) begin
        shaDone <= 1'b1;
        shaHash <= hashOf(curNonce);
        shaBusy <= 1'b0;
      end else begin
        shaCnt <= shaCnt - 1;
      end
    end
    if (shaStart) begin
      shaBusy <= 1'b1;
      shaCnt  <= shaLat - 1;
    end
    if (memRdEn) memRdata <= chunkPattern(memAddr);
  end

  int                 wrCount = 0, rdCount = 0, shaCount = 0, busyCycles = 0;
  int                 startsInAttempt = 0, readsInAttempt = 0;
  logic [NONCE_W-1:0] wrQ[$];
  logic [ADDR_W-1:0]  expAddr = '0;
  logic [POS_W-1:0]   expPos = '0;

  // Strobe monitor: exclusivity, write/read addressing and the chunk handed to the core.
  always @(negedge clock) begin
    if (resetN) begin
      if (memWrEn || memRdEn || shaStart) begin
        vectors++;
        if (int'(memWrEn) + int'(memRdEn) + int'(shaStart) > 1) begin
          miscompares++;
          $display("[TB] FAIL strobe_exclusive: wr=%0b rd=%0b sha=%0b required at most one", memWrEn, memRdEn, shaStart);
        end
      end
      if (memWrEn) begin
        wrQ.push_back(memWdata);
        curNonce = memWdata;
        wrCount++;
        startsInAttempt = 0;
        readsInAttempt = 0;
        vectors++;
        if (memAddr !== expAddr || memWpos !== expPos) begin
          miscompares++;
          $display("[TB] FAIL write_addr: addr=%0h pos=%0h required addr=%0h pos=%0h", memAddr, memWpos, expAddr, expPos);
        end
      end
      if (memRdEn) begin
        vectors++;
        if (memAddr !== ADDR_W'(readsInAttempt)) begin
          miscompares++;
          $display("[TB] FAIL read_addr: got %0h required %0h", memAddr, readsInAttempt);
        end
        readsInAttempt++;
        rdCount++;
      end
      if (shaStart) begin
        vectors++;
        if (shaChunk !== chunkPattern(ADDR_W'(startsInAttempt)) || shaInit !== (startsInAttempt == 0)) begin
          miscompares++;
          $display("[TB] FAIL sha_chunk: init=%0b chunk[31:0]=%0h required init=%0b chunk[31:0]=%0h", shaInit, shaChunk[31:0], startsInAttempt == 0, chunkPattern(ADDR_W'(startsInAttempt)) & 32'hFFFF_FFFF);
        end
        startsInAttempt++;
        shaCount++;
      end
      if (busy && !found && !exhausted) busyCycles++;
    end
  end

  task automatic applyStimulus(input int n, input logic [NONCE_W-1:0] s, input logic [NONCE_W-1:0] e, input int d);
    @(posedge clock); #1;
    numChunks  = CNT_W'(n);
    nonceAddr  = ADDR_W'($urandom);
    noncePos   = POS_W'($urandom);
    nonceStart = s;
    nonceEnd   = e;
    difficulty = 9'(d);
    expAddr    = nonceAddr;
    expPos     = noncePos;
    wrQ.delete();
    shaCount   = 0;
    busyCycles = 0;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
  endtask

  task automatic runSearch(input int nIn, input logic [NONCE_W-1:0] s, input logic [NONCE_W-1:0] e,
                           input int diffIn, input int lat, input int mode);
    int effN, effD, expAtt, budget;
    bit expFound, ok;
    logic [NONCE_W-1:0] n;
    logic [NONCE_W-1:0] expWr[$];
    effN = (nIn == 0) ? 1 : ((nIn > MAX_CHUNKS) ? MAX_CHUNKS : nIn);
    effD = (diffIn > 256) ? 256 : diffIn;
    hashMode = mode;
    shaLat = lat;
    n = s;
    expAtt = 0;
    expFound = 1'b0;
    for (int k = 0; k < 64; k++) begin
      expWr.push_back(n);
      expAtt++;
      if (leadingZeros(hashOf(n)) >= effD) begin
        expFound = 1'b1;
        break;
      end
      if (n == e) break;
      n = n + 1;
    end
    budget = expAtt * (2 + effN * (3 + lat)) + 50;
    applyStimulus(nIn, s, e, diffIn);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clock);
      if (found || exhausted) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL search_timeout: no found/exhausted within %0d cycles", budget);
      return;
    end
    vectors++;
    if (found !== expFound || exhausted !== !expFound) begin
      miscompares++;
      $display("[TB] FAIL outcome: found=%0b exhausted=%0b required found=%0b exhausted=%0b", found, exhausted, expFound, !expFound);
    end
    vectors++;
    if (expFound && nonceOut !== n) begin
      miscompares++;
      $display("[TB] FAIL nonce_out: got %0h required %0h", nonceOut, n);
    end
    vectors++;
    if (attempts !== NONCE_W'(expAtt)) begin
      miscompares++;
      $display("[TB] FAIL attempts: got %0d required %0d", attempts, expAtt);
    end
    vectors++;
    if (wrQ.size() != expWr.size()) begin
      miscompares++;
      $display("[TB] FAIL write_count: got %0d required %0d", wrQ.size(), expWr.size());
    end else begin
      foreach (expWr[i]) begin
        vectors++;
        if (wrQ[i] !== expWr[i]) begin
          miscompares++;
          $display("[TB] FAIL write_nonce[%0d]: got %0h required %0h", i, wrQ[i], expWr[i]);
        end
      end
    end
    vectors++;
    if (shaCount != expAtt * effN) begin
      miscompares++;
      $display("[TB] FAIL sha_starts: got %0d required %0d", shaCount, expAtt * effN);
    end
    vectors++;
    if (busyCycles != expAtt * (2 + effN * (3 + lat))) begin
      miscompares++;
      $display("[TB] FAIL latency: got %0d cycles required %0d", busyCycles, expAtt * (2 + effN * (3 + lat)));
    end
    vectors++;
    if (stateOut !== (expFound ? 4'd7 : 4'd8) || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL end_state: state=%0d busy=%0b required state=%0d busy=1", stateOut, busy, expFound ? 7 : 8);
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({busy, found, exhausted, memRdEn, memWrEn, shaStart, shaInit} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b required 0", {busy, found, exhausted, memRdEn, memWrEn, shaStart, shaInit});
    end
    vectors++;
    if (stateOut !== 4'd0 || nonceOut !== '0 || attempts !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: state=%0d nonce_out=%0h attempts=%0d required all 0", stateOut, nonceOut, attempts);
    end
    vectors++;
    if (memAddr !== '0 || memWpos !== '0 || memWdata !== '0 || shaChunk !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: addr=%0h wpos=%0h wdata=%0h chunk_nonzero=%0b required 0", memAddr, memWpos, memWdata, shaChunk != '0);
    end
    @(posedge clock); #1;
    resetN = 1'b1;
  endtask

  task automatic test_abort;
    int wr0, rd0, sh0;
    hashMode = 0;
    shaLat = 4;
    applyStimulus(3, 32'h0, 32'd100, 256);
    for (int c = 0; c < 400 && shaCount < 5; c++) @(negedge clock);
    vectors++;
    if (shaCount != 5) begin
      miscompares++;
      $display("[TB] FAIL abort_setup: sha starts %0d required 5", shaCount);
    end
    @(posedge clock); #1;
    abort = 1'b1;
    @(negedge clock);
    vectors++;
    if (memRdEn || memWrEn || shaStart) begin
      miscompares++;
      $display("[TB] FAIL abort_strobes: wr=%0b rd=%0b sha=%0b required 0", memWrEn, memRdEn, shaStart);
    end
    @(posedge clock); #1;
    vectors++;
    if (busy !== 1'b0 || stateOut !== 4'd0 || attempts !== 32'd1 || found !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: busy=%0b state=%0d attempts=%0d found=%0b required 0/0/1/0", busy, stateOut, attempts, found);
    end
    abort = 1'b0;
    wr0 = wrCount; rd0 = rdCount; sh0 = shaCount;
    repeat (12) @(negedge clock);
    vectors++;
    if (wrCount != wr0 || rdCount != rd0 || shaCount != sh0 || stateOut !== 4'd0 || attempts !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL abort_quiet: strobes wr=%0d rd=%0d sha=%0d state=%0d attempts=%0d required none/0/1", wrCount - wr0, rdCount - rd0, shaCount - sh0, stateOut, attempts);
    end
    runSearch(2, 32'h40, 32'h48, 3, 3, 2);
  endtask

  task automatic test_async_reset;
    bit seen;
    hashMode = 0;
    shaLat = 3;
    applyStimulus(2, 32'h0, 32'd50, 256);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clock);
      if (stateOut == 4'd3) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL rdwait_seen: state 3 not reached");
    end
    #2 resetN = 1'b0;
    #1;
    vectors++;
    if ({busy, found, exhausted, memRdEn, memWrEn, shaStart} !== 6'b0 || stateOut !== 4'd0 ||
        attempts !== '0 || shaChunk !== '0 || memWpos !== '0 || memWdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: busy=%0b state=%0d attempts=%0d wdata=%0h required all 0", busy, stateOut, attempts, memWdata);
    end
    @(posedge clock); #1;
    resetN = 1'b1;
    repeat (8) @(posedge clock);
    runSearch(2, 32'h7, 32'h9, 0, 2, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [NONCE_W-1:0] s;
      hashSeed = $urandom;
      s = $urandom;
      runSearch($urandom_range(0, 17), s, s + $urandom_range(0, 10), $urandom_range(0, 5), $urandom_range(2, 5), 2);
    end
  endtask

  initial begin
    test_reset();
    runSearch(2, 32'h10, 32'h20, 0, 3, 0);
    hashTarget = 32'h25;
    runSearch(3, 32'h20, 32'h30, 12, 2, 1);
    runSearch(1, 32'hFFFF_FFFE, 32'h1, 256, 2, 0);
    runSearch(0, 32'h100, 32'h105, 300, 2, 3);
    runSearch(20, 32'h5, 32'h6, 300, 2, 0);
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
